dense_stream_mac: RTL and testbench
===================================

# dense_stream_mac

Fully-connected classifier stage downstream of the L2 ReLU/2x2 max-pool unit. It consumes the pooled, non-negative feature map as a flattened element stream over a valid/ready handshake, and fetches signed weights from an external synchronous weight memory. Each element is multiplied against every output neuron's weight, and the block holds NUM_OUT signed accumulators. When the last element has been processed, it presents the logits and pulses `out_valid`.

## Interface
- `IN_LEN`, 3136: flattened input length (14×14×16); stream order is row, then column, then channel fastest.
- `NUM_OUT`, 10: output neurons (classes).
- `DATA_W`, 18: activation width, unsigned (post-ReLU).
- `WGT_W`, 18: weight width, two's complement.
- `ACC_W`, 50: accumulator width; must satisfy ACC_W ≥ DATA_W+WGT_W+1+clog2(IN_LEN).

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: begin a new inference; honoured only in IDLE.
- `in_data` in DATA_W: activation element.
- `in_valid` in 1: `in_data` valid.
- `in_ready` out 1: block accepts an element this cycle.
- `w_rd_en` out 1: weight read strobe.
- `w_addr` out clog2(IN_LEN·NUM_OUT): weight address = in_idx·NUM_OUT + o.
- `w_data` in WGT_W: weight; valid exactly 1 cycle after `w_rd_en`.
- `logits` out [NUM_OUT][ACC_W] signed: accumulator results.
- `out_valid` out 1: one-cycle pulse when `logits` are final.
- `busy` out 1: high in any state other than IDLE.

## Operation
- States are IDLE, WAIT_IN, MAC, DRAIN and DONE.
- **IDLE:** On `start`, clear all accumulators and set in_idx=0, then go to WAIT_IN.
- **WAIT_IN:** `in_ready`=1. On `in_valid`&&`in_ready`, latch `in_data` into x and set o=0, then go to MAC.
- **MAC:** Issue `w_rd_en`=1 with `w_addr`=in_idx·NUM_OUT+o, and increment o.
  - After issuing o=NUM_OUT-1, go to DRAIN.
  - The accumulate stage runs one cycle behind: acc[o_d] += x·`w_data`.
- **DRAIN:** Perform the final accumulate for o=NUM_OUT-1.
  - If in_idx==IN_LEN-1, go to DONE.
  - Otherwise increment in_idx and go to WAIT_IN.
- **DONE:** Pulse `out_valid` for this single cycle, then go to IDLE.
- `logits` hold their values until the next accepted `start`.
- **Arithmetic:**
  - x is zero-extended to DATA_W+1 bits, signed.
  - The product is DATA_W+WGT_W+1 bits, signed, and sign-extended to ACC_W.
  - There is no saturation; the ACC_W rule guarantees no overflow.
- `start` is ignored outside IDLE. In particular, `start` asserted in the DONE cycle is ignored.
- `in_valid` outside WAIT_IN is ignored and no data is consumed.
- `w_data` is sampled only on the cycle after a `w_rd_en`.

## Timing
- **Reset values:** state=IDLE, `in_ready`=0, `w_rd_en`=0, `w_addr`=0, `logits` all 0, `out_valid`=0, `busy`=0.
- **Reset mid-operation:** returns to IDLE on the next edge. Accumulators clear to 0 and any in-flight weight read is discarded.
- **Per-element cost:** 1 accept cycle + NUM_OUT MAC cycles + 1 DRAIN cycle = NUM_OUT+2 cycles (12 at defaults), with `in_valid` held continuously.
- **Full-inference latency:** `start`→`out_valid` = 1 + IN_LEN·(NUM_OUT+2) + 1 cycles, plus any `in_valid` stall cycles.
- `in_ready` is high only in WAIT_IN, so at most one element is accepted per WAIT_IN visit.
- **Back-pressure:** input stalls while `in_valid`=0 extend only WAIT_IN. Accumulators are untouched during a stall.

## Configuration
- **`DENSE_ZERO_SKIP_EN` defined:** an accepted element equal to 0 skips MAC and DRAIN.
  - No weight reads are issued for that element.
  - The block increments in_idx and returns to WAIT_IN on the next cycle, or goes to DONE if it was the last element.
  - A zero element therefore costs 1 cycle.
- **Not defined:** every element, including 0, costs NUM_OUT+2 cycles and issues NUM_OUT reads.
- `logits` are identical in both builds.

## Structure
- Shared package `cnn_pkg` holds:
  - the state enum `dense_state_t`;
  - the `DATA_W`/`WGT_W` defaults;
  - the `FMAP_H2`/`FMAP_W2`/`CH2` pooled-map constants used to derive IN_LEN.
- One sub-module, `mac_unit`, holds the signed multiply, sign extension and indexed accumulator update. It has inputs x, w, o and en.
- The FSM, counters and weight addressing stay in the top.

## Test plan
- **All-ones stream:** IN_LEN=4, NUM_OUT=2, inputs 1,1,1,1, weight memory w[a]=a.
  - Required: logits = {0+2+4+6, 1+3+5+7} = {12,16}.
  - Required: `out_valid` pulses once, 1+4·4+1 = 18 cycles after `start`.
- **Negative weights:** input 3, all weights −5, IN_LEN=4, NUM_OUT=2.
  - Required: each logit = −60, sign-extended correctly.
- **Back-pressure:** drop `in_valid` for 7 cycles between elements.
  - Required: logits unchanged versus the no-stall run; latency grows by exactly 7.
  - Required: `in_ready` high only in WAIT_IN.
- **Reset mid-run:** assert `rst` during MAC of element 2, then restart.
  - Required: all outputs return to reset values; the rerun matches the golden result.
- **Zero-skip:** input stream 0,0,5,0 with `DENSE_ZERO_SKIP_EN` defined.
  - Required: only 2 `w_rd_en` pulses are issued, and logits match the non-skip build.
- **Maximum magnitude:** in=2^18−1 and w=−2^17 for the full default IN_LEN.
  - Required: each logit = −(2^18−1)·2^17·3136 with no wrap.
  - Required: `start` asserted during `busy` is ignored.

Source files
------------

// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cnn_pkg
// Brief    : Shared types and constants for the CNN classifier datapath.
// Revision : 1.0
// ============================================================================
package cnn_pkg;

    // Pooled L2 feature map geometry feeding the dense stage.
    localparam int FMAP_H2      = 14;
    localparam int FMAP_W2      = 14;
    localparam int CH2          = 16;
    localparam int DENSE_IN_LEN = FMAP_H2 * FMAP_W2 * CH2;

    localparam int DENSE_DATA_W = 18;
    localparam int DENSE_WGT_W  = 18;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_IN = 3'd1,
        ST_MAC     = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_DONE    = 3'd4
    } dense_state_t;

    // Smallest accumulator width that cannot overflow over a full inference.
    function automatic int dense_min_acc_w(input int data_w, input int wgt_w, input int in_len);
        return data_w + wgt_w + 1 + $clog2(in_len);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dense_stream_mac_if.sv
`default_nettype none
// ============================================================================
// Module   : dense_stream_mac_if
// Brief    : Element stream, weight-memory and logit bundle of dense_stream_mac.
// Revision : 1.0
// ============================================================================
interface dense_stream_mac_if #(
    parameter int DATA_W  = 18,
    parameter int WGT_W   = 18,
    parameter int ACC_W   = 50,
    parameter int NUM_OUT = 10,
    parameter int ADDR_W  = 15
);
    logic                     start;
    logic [DATA_W-1:0]        in_data;
    logic                     in_valid;
    logic                     in_ready;
    logic                     w_rd_en;
    logic [ADDR_W-1:0]        w_addr;
    logic signed [WGT_W-1:0]  w_data;
    logic signed [ACC_W-1:0]  logits [NUM_OUT];
    logic                     out_valid;
    logic                     busy;

    modport master (
        output start, in_data, in_valid, w_data,
        input  in_ready, w_rd_en, w_addr, logits, out_valid, busy
    );

    modport slave (
        input  start, in_data, in_valid, w_data,
        output in_ready, w_rd_en, w_addr, logits, out_valid, busy
    );
endinterface
`default_nettype wire

// File: rtl/mac_unit.sv
`default_nettype none
// ============================================================================
// Module   : mac_unit
// Brief    : Signed multiply of unsigned activation by weight, accumulated into
//            one of NUM_OUT indexed accumulators.
// Revision : 1.0
// ============================================================================
module mac_unit
    import cnn_pkg::*;
#(
    parameter int DATA_W  = DENSE_DATA_W,
    parameter int WGT_W   = DENSE_WGT_W,
    parameter int ACC_W   = 50,
    parameter int NUM_OUT = 10,
    parameter int O_W     = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    input  wire logic                    clr,
    input  wire logic                    en,
    input  wire logic [DATA_W-1:0]       x,
    input  wire logic signed [WGT_W-1:0] w,
    input  wire logic [O_W-1:0]          o,
    output logic signed [ACC_W-1:0]      acc [NUM_OUT]
);
    localparam int c_PROD_W = DATA_W + WGT_W + 1;

    logic signed [DATA_W:0]     w_x_s;
    logic signed [c_PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]    w_prod_ext;
    logic signed [ACC_W-1:0]    r_acc [NUM_OUT];

    // Activation is post-ReLU, so a zero MSB makes it a non-negative signed value.
    assign w_x_s      = $signed({1'b0, x});
    assign w_prod     = c_PROD_W'(w_x_s) * c_PROD_W'(w);
    assign w_prod_ext = {{(ACC_W - c_PROD_W){w_prod[c_PROD_W-1]}}, w_prod};

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                r_acc[i] <= '0;
            end
        end else if (en) begin
            r_acc[o] <= r_acc[o] + w_prod_ext;
        end
    end

    assign acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/dense_stream_mac.sv
`default_nettype none
// ============================================================================
// Module   : dense_stream_mac
// Brief    : Streaming fully-connected layer; one element in, NUM_OUT weight
//            reads and accumulates per element. Optional DENSE_ZERO_SKIP_EN
//            skips weight traffic for zero activations.
// Revision : 1.0
// ============================================================================
module dense_stream_mac
    import cnn_pkg::*;
#(
    parameter int IN_LEN  = DENSE_IN_LEN,
    parameter int NUM_OUT = 10,
    parameter int DATA_W  = DENSE_DATA_W,
    parameter int WGT_W   = DENSE_WGT_W,
    parameter int ACC_W   = 50
) (
    input  wire logic         clk,
    input  wire logic         rst,
    dense_stream_mac_if.slave bus
);
    localparam int c_ADDR_W = $clog2(IN_LEN * NUM_OUT);
    localparam int c_IDX_W  = (IN_LEN > 1) ? $clog2(IN_LEN) : 1;
    localparam int c_O_W    = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(IN_LEN - 1);
    localparam logic [c_O_W-1:0]   c_LAST_O   = c_O_W'(NUM_OUT - 1);
`ifdef DENSE_ZERO_SKIP_EN
    localparam logic [c_ADDR_W-1:0] c_ADDR_STEP = c_ADDR_W'(NUM_OUT);
`endif

    if (ACC_W < dense_min_acc_w(DATA_W, WGT_W, IN_LEN)) begin : g_acc_w_bad
        $error("dense_stream_mac: ACC_W too narrow for IN_LEN");
    end

    dense_state_t               r_state;
    dense_state_t               w_state_nxt;
    logic [c_IDX_W-1:0]         r_in_idx;
    logic [c_O_W-1:0]           r_o;
    logic [c_O_W-1:0]           r_o_d;
    logic [c_ADDR_W-1:0]        r_addr;
    logic [DATA_W-1:0]          r_x;
    logic                       r_acc_en;
    logic                       w_clr;
    logic                       w_last;
    logic                       w_zero;
    logic signed [ACC_W-1:0]    w_acc [NUM_OUT];

    assign w_clr  = (r_state == ST_IDLE) && bus.start;
    assign w_last = (r_in_idx == c_LAST_IDX);
`ifdef DENSE_ZERO_SKIP_EN
    assign w_zero = (bus.in_data == '0);
`else
    assign w_zero = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        bus.in_ready  = 1'b0;
        bus.w_rd_en   = 1'b0;
        bus.w_addr    = '0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b1;
        unique case (r_state)
            ST_IDLE: begin
                bus.busy = 1'b0;
                if (bus.start) w_state_nxt = ST_WAIT_IN;
            end
            ST_WAIT_IN: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    if (w_zero) w_state_nxt = w_last ? ST_DONE : ST_WAIT_IN;
                    else        w_state_nxt = ST_MAC;
                end
            end
            ST_MAC: begin
                bus.w_rd_en = 1'b1;
                bus.w_addr  = r_addr;
                if (r_o == c_LAST_O) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                w_state_nxt = w_last ? ST_DONE : ST_WAIT_IN;
            end
            ST_DONE: begin
                bus.out_valid = 1'b1;
                w_state_nxt   = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // r_addr walks in_idx*NUM_OUT+o incrementally, so no multiplier is needed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_idx <= '0;
            r_o      <= '0;
            r_o_d    <= '0;
            r_addr   <= '0;
            r_x      <= '0;
            r_acc_en <= 1'b0;
        end else begin
            r_acc_en <= (r_state == ST_MAC);
            r_o_d    <= r_o;
            unique case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_in_idx <= '0;
                        r_addr   <= '0;
                    end
                end
                ST_WAIT_IN: begin
                    if (bus.in_valid) begin
                        r_x <= bus.in_data;
                        r_o <= '0;
`ifdef DENSE_ZERO_SKIP_EN
                        if (w_zero) begin
                            r_addr <= r_addr + c_ADDR_STEP;
                            if (!w_last) r_in_idx <= r_in_idx + c_IDX_W'(1);
                        end
`endif
                    end
                end
                ST_MAC: begin
                    r_o    <= r_o + c_O_W'(1);
                    r_addr <= r_addr + c_ADDR_W'(1);
                end
                ST_DRAIN: begin
                    if (!w_last) r_in_idx <= r_in_idx + c_IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Accumulate runs one cycle behind the read so it lines up with w_data.
    mac_unit #(
        .DATA_W  (DATA_W),
        .WGT_W   (WGT_W),
        .ACC_W   (ACC_W),
        .NUM_OUT (NUM_OUT),
        .O_W     (c_O_W)
    ) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (w_clr),
        .en  (r_acc_en),
        .x   (r_x),
        .w   (bus.w_data),
        .o   (r_o_d),
        .acc (w_acc)
    );

    assign bus.logits = w_acc;

endmodule
`default_nettype wire

// File: tb/tb_dense_stream_mac.sv
`default_nettype none
// ============================================================================
// Module   : tb_dense_stream_mac
// Brief    : Directed bench; small (IN_LEN=4, NUM_OUT=2) and default-size DUTs.
// Revision : 1.0
// ============================================================================
module tb_dense_stream_mac;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;
    int   checks;
    int   errors;
    int   wmode_a;
    int   rd_cnt_a = 0;
    int   ov_cnt_a = 0;
    int   ready_bad_a = 0;

    localparam logic signed [49:0] c_MAX_EXP = -50'sd107751728480256;

    dense_stream_mac_if #(.DATA_W(18), .WGT_W(18), .ACC_W(50), .NUM_OUT(2),  .ADDR_W(3))  ifa ();
    dense_stream_mac_if #(.DATA_W(18), .WGT_W(18), .ACC_W(50), .NUM_OUT(10), .ADDR_W(15)) ifb ();

    dense_stream_mac #(.IN_LEN(4), .NUM_OUT(2), .DATA_W(18), .WGT_W(18), .ACC_W(50)) dut_a (
        .clk (clk), .rst (rst_a), .bus (ifa.slave)
    );
    dense_stream_mac #(.IN_LEN(3136), .NUM_OUT(10), .DATA_W(18), .WGT_W(18), .ACC_W(50)) dut_b (
        .clk (clk), .rst (rst_b), .bus (ifb.slave)
    );

    // Synchronous weight memories; junk is driven whenever no read was issued.
    always @(posedge clk) begin
        if (ifa.w_rd_en) ifa.w_data <= (wmode_a == 0) ? 18'(ifa.w_addr) : -18'sd5;
        else             ifa.w_data <= 18'h2AAAA;
        if (ifb.w_rd_en) ifb.w_data <= 18'h20000;
        else             ifb.w_data <= 18'h1FFFF;
    end

    always @(negedge clk) begin
        if (ifa.w_rd_en)   rd_cnt_a++;
        if (ifa.out_valid) ov_cnt_a++;
        if (ifa.in_ready && (ifa.w_rd_en || ifa.out_valid || !ifa.busy)) ready_bad_a++;
    end

    // Runs one inference on DUT A; lat counts the start cycle as 1 and the
    // out_valid cycle inclusive.
    task automatic run_a(input logic [17:0] vals [4], input int stall_at, output int lat);
        lat = -1;
        @(negedge clk);
        ifa.start = 1'b1;
        fork
            begin
                for (int k = 0; k < 4; k++) begin
                    int t;
                    if (k == stall_at) begin
                        ifa.in_valid = 1'b0;
                        t = 0;
                        while (!ifa.in_ready && t < 100) begin @(negedge clk); t++; end
                        repeat (7) @(negedge clk);
                    end
                    ifa.in_data  = vals[k];
                    ifa.in_valid = 1'b1;
                    t = 0;
                    while (!ifa.in_ready && t < 100) begin @(negedge clk); t++; end
                    @(negedge clk);
                end
                ifa.in_valid = 1'b0;
            end
            begin
                int cyc;
                @(negedge clk);
                ifa.start = 1'b0;
                cyc = 2;
                while (!ifa.out_valid && cyc < 200) begin @(negedge clk); cyc++; end
                lat = ifa.out_valid ? cyc : -1;
            end
        join
    endtask

    task automatic test_reset();
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (ifa.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", ifa.in_ready); end
        checks++; if (ifa.w_rd_en !== 1'b0) begin errors++; $display("FAIL rst_w_rd_en got %b exp 0", ifa.w_rd_en); end
        checks++; if (ifa.w_addr !== 3'd0) begin errors++; $display("FAIL rst_w_addr got %0d exp 0", ifa.w_addr); end
        checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", ifa.out_valid); end
        checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", ifa.busy); end
        for (int i = 0; i < 2; i++) begin
            checks++; if (ifa.logits[i] !== 50'sd0) begin errors++; $display("FAIL rst_logit%0d got %0d exp 0", i, ifa.logits[i]); end
        end
        checks++; if (ifb.busy !== 1'b0) begin errors++; $display("FAIL rst_busy_b got %b exp 0", ifb.busy); end
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_all_ones();
        logic [17:0] v [4] = '{18'd1, 18'd1, 18'd1, 18'd1};
        int lat, rd0, ov0;
        wmode_a = 0;
        rd0 = rd_cnt_a;
        ov0 = ov_cnt_a;
        run_a(v, -1, lat);
        checks++; if (lat != 18) begin errors++; $display("FAIL ones_latency got %0d exp 18", lat); end
        checks++; if (ifa.logits[0] !== 50'sd12) begin errors++; $display("FAIL ones_logit0 got %0d exp 12", ifa.logits[0]); end
        checks++; if (ifa.logits[1] !== 50'sd16) begin errors++; $display("FAIL ones_logit1 got %0d exp 16", ifa.logits[1]); end
        // start raised during DONE must not launch another inference
        ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL done_start_busy got %b exp 0", ifa.busy); end
        repeat (4) @(negedge clk);
        checks++; if (ifa.logits[1] !== 50'sd16) begin errors++; $display("FAIL ones_hold got %0d exp 16", ifa.logits[1]); end
        checks++; if (rd_cnt_a - rd0 != 8) begin errors++; $display("FAIL ones_reads got %0d exp 8", rd_cnt_a - rd0); end
        checks++; if (ov_cnt_a - ov0 != 1) begin errors++; $display("FAIL ones_out_valid_pulses got %0d exp 1", ov_cnt_a - ov0); end
    endtask

    task automatic test_negative_weights();
        logic [17:0] v [4] = '{18'd3, 18'd3, 18'd3, 18'd3};
        int lat;
        wmode_a = 1;
        run_a(v, -1, lat);
        for (int i = 0; i < 2; i++) begin
            checks++; if (ifa.logits[i] !== -50'sd60) begin errors++; $display("FAIL neg_logit%0d got %0d exp -60", i, ifa.logits[i]); end
        end
        @(negedge clk);
    endtask

    task automatic test_back_pressure();
        logic [17:0] v [4] = '{18'd1, 18'd1, 18'd1, 18'd1};
        int lat, bad0;
        wmode_a = 0;
        bad0 = ready_bad_a;
        run_a(v, 2, lat);
        checks++; if (lat != 25) begin errors++; $display("FAIL stall_latency got %0d exp 25", lat); end
        checks++; if (ifa.logits[0] !== 50'sd12) begin errors++; $display("FAIL stall_logit0 got %0d exp 12", ifa.logits[0]); end
        checks++; if (ifa.logits[1] !== 50'sd16) begin errors++; $display("FAIL stall_logit1 got %0d exp 16", ifa.logits[1]); end
        checks++; if (ready_bad_a != bad0) begin errors++; $display("FAIL ready_outside_wait got %0d exp 0", ready_bad_a - bad0); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        logic [17:0] v [4] = '{18'd1, 18'd1, 18'd1, 18'd1};
        int lat, t;
        wmode_a = 0;
        ifa.in_data  = 18'd1;
        ifa.in_valid = 1'b1;
        ifa.start    = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        t = 0;
        while (!(ifa.w_rd_en && ifa.w_addr == 3'd4) && t < 100) begin @(negedge clk); t++; end
        checks++; if (t >= 100) begin errors++; $display("FAIL midrst_reach_mac got timeout exp element2 read"); end
        rst_a = 1'b1;
        @(negedge clk);
        rst_a        = 1'b0;
        ifa.in_valid = 1'b0;
        checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", ifa.busy); end
        checks++; if (ifa.w_rd_en !== 1'b0) begin errors++; $display("FAIL midrst_w_rd_en got %b exp 0", ifa.w_rd_en); end
        checks++; if (ifa.w_addr !== 3'd0) begin errors++; $display("FAIL midrst_w_addr got %0d exp 0", ifa.w_addr); end
        checks++; if (ifa.in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready got %b exp 0", ifa.in_ready); end
        checks++; if (ifa.logits[0] !== 50'sd0) begin errors++; $display("FAIL midrst_logit0 got %0d exp 0", ifa.logits[0]); end
        @(negedge clk);
        checks++; if (ifa.logits[1] !== 50'sd0) begin errors++; $display("FAIL midrst_logit1_after got %0d exp 0", ifa.logits[1]); end
        run_a(v, -1, lat);
        checks++; if (lat != 18) begin errors++; $display("FAIL rerun_latency got %0d exp 18", lat); end
        checks++; if (ifa.logits[0] !== 50'sd12) begin errors++; $display("FAIL rerun_logit0 got %0d exp 12", ifa.logits[0]); end
        checks++; if (ifa.logits[1] !== 50'sd16) begin errors++; $display("FAIL rerun_logit1 got %0d exp 16", ifa.logits[1]); end
        @(negedge clk);
    endtask

    task automatic test_zero_skip();
        logic [17:0] v [4] = '{18'd0, 18'd0, 18'd5, 18'd0};
        int lat, rd0, exp_rd, exp_lat;
`ifdef DENSE_ZERO_SKIP_EN
        exp_rd  = 2;
        exp_lat = 9;
`else
        exp_rd  = 8;
        exp_lat = 18;
`endif
        wmode_a = 0;
        rd0 = rd_cnt_a;
        run_a(v, -1, lat);
        @(negedge clk);
        checks++; if (ifa.logits[0] !== 50'sd20) begin errors++; $display("FAIL zskip_logit0 got %0d exp 20", ifa.logits[0]); end
        checks++; if (ifa.logits[1] !== 50'sd25) begin errors++; $display("FAIL zskip_logit1 got %0d exp 25", ifa.logits[1]); end
        checks++; if (rd_cnt_a - rd0 != exp_rd) begin errors++; $display("FAIL zskip_reads got %0d exp %0d", rd_cnt_a - rd0, exp_rd); end
        checks++; if (lat != exp_lat) begin errors++; $display("FAIL zskip_latency got %0d exp %0d", lat, exp_lat); end
    endtask

    task automatic test_max_magnitude();
        int cyc;
        ifb.in_data  = 18'h3FFFF;
        ifb.in_valid = 1'b1;
        @(negedge clk);
        ifb.start = 1'b1;
        @(negedge clk);
        ifb.start = 1'b0;
        cyc = 2;
        while (!ifb.out_valid && cyc < 40000) begin
            if (cyc == 100) begin
                checks++; if (ifb.busy !== 1'b1) begin errors++; $display("FAIL max_busy got %b exp 1", ifb.busy); end
            end
            ifb.start = (cyc == 100) || (cyc >= 200 && cyc < 203);
            @(negedge clk);
            cyc++;
        end
        ifb.start    = 1'b0;
        ifb.in_valid = 1'b0;
        checks++; if (cyc != 37634) begin errors++; $display("FAIL max_latency got %0d exp 37634", cyc); end
        for (int i = 0; i < 10; i++) begin
            checks++; if (ifb.logits[i] !== c_MAX_EXP) begin errors++; $display("FAIL max_logit%0d got %0d exp %0d", i, ifb.logits[i], c_MAX_EXP); end
        end
        @(negedge clk);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        wmode_a      = 0;
        rst_a        = 1'b1;
        rst_b        = 1'b1;
        ifa.start    = 1'b0;
        ifa.in_valid = 1'b0;
        ifa.in_data  = '0;
        ifb.start    = 1'b0;
        ifb.in_valid = 1'b0;
        ifb.in_data  = '0;
        test_reset();
        test_all_ones();
        test_negative_weights();
        test_back_pressure();
        test_reset_mid_run();
        test_zero_skip();
        test_max_magnitude();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
